// File: rtl/tb_stream_pkg.sv
// Shared types and helpers for the AXI-stream packet router.
package tb_stream_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // A channel index needs at least one bit even for two channels.
    function automatic int chan_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with same-cycle push/pop; a push at full is accepted
// only when a pop frees the head slot in the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          din,
    input  logic                       push,
    input  logic                       pop,
    output logic                       push_ok,
    output logic [DATA_W-1:0]          head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_stream_router.sv
// Buffers pushed words and emits them as framed AXI-stream packets, routing
// each whole packet to the channel selected when the packet starts.
module axis_stream_router
    import tb_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int N_CH   = 5,
    parameter int LEN_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           din,
    input  logic                        push,
    input  logic                        op_en,
    input  logic [chan_w(N_CH)-1:0]     sel,
    input  logic [LEN_W-1:0]            pkt_len,
    input  logic                        clr_err,
    input  logic [N_CH-1:0]             tready,
    output logic [N_CH*DATA_W-1:0]      tdata,
    output logic [N_CH-1:0]             tvalid,
    output logic [N_CH-1:0]             tlast,
    output logic [$clog2(DEPTH):0]      buff_count,
    output logic                        empty,
    output logic                        full,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        overflow,
    output logic                        sel_err
);
    localparam int CW    = chan_w(N_CH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    state_t            state;
    logic [CW-1:0]     ch;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  beat;
    logic [DATA_W-1:0] head;
    logic              push_ok;
    logic              hs;
    logic              last_beat;
    logic              start_try;
    logic              sel_bad;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .push    (push),
        .pop     (hs),
        .push_ok (push_ok),
        .head    (head),
        .count   (buff_count),
        .empty   (empty),
        .full    (full)
    );

    assign busy      = (state == ACTIVE);
    assign hs        = busy & ~empty & tready[ch];
    // Flush mode (len==0) ends the packet on whatever word is currently last.
    assign last_beat = (len != '0) ? (beat == len - 1'b1) : (buff_count == CNT_W'(1));
    assign sel_bad   = (int'(sel) >= N_CH);
    assign start_try = (state == IDLE) & op_en & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ch       <= '0;
            len      <= '0;
            beat     <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_try && !sel_bad) begin
                        ch    <= sel;
                        len   <= pkt_len;
                        beat  <= '0;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (hs) begin
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state    <= IDLE;
                            pkt_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky flags: a same-cycle set takes priority over clr_err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            if (push && !push_ok)
                overflow <= 1'b1;
            else if (clr_err)
                overflow <= 1'b0;
            if (start_try && sel_bad)
                sel_err <= 1'b1;
            else if (clr_err)
                sel_err <= 1'b0;
        end
    end

    always_comb begin
        tvalid = '0;
        tlast  = '0;
        tdata  = '0;
        if (busy && !empty) begin
            tvalid[ch]                          = 1'b1;
            tlast[ch]                           = last_beat;
            tdata[int'(ch)*DATA_W +: DATA_W]    = head;
        end
    end

endmodule

// File: tb/tb_axis_stream_router.sv
// Randomised and directed bench for axis_stream_router against a queue-based model.
module tb_axis_stream_router;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int N_CH   = 5;
    localparam int LEN_W  = 8;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [DATA_W-1:0]      din = '0;
    logic                   push = 1'b0;
    logic                   op_en = 1'b0;
    logic [2:0]             sel = '0;
    logic [LEN_W-1:0]       pkt_len = '0;
    logic                   clr_err = 1'b0;
    logic [N_CH-1:0]        tready = '0;
    logic [N_CH*DATA_W-1:0] tdata;
    logic [N_CH-1:0]        tvalid;
    logic [N_CH-1:0]        tlast;
    logic [4:0]             buff_count;
    logic                   empty, full, busy, pkt_done, overflow, sel_err;

    axis_stream_router #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .N_CH(N_CH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .push(push), .op_en(op_en), .sel(sel),
        .pkt_len(pkt_len), .clr_err(clr_err), .tready(tready), .tdata(tdata),
        .tvalid(tvalid), .tlast(tlast), .buff_count(buff_count), .empty(empty),
        .full(full), .busy(busy), .pkt_done(pkt_done), .overflow(overflow),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a word queue plus the current packet's route and progress.
    logic [7:0] q[$];
    bit         m_busy, m_done, m_ovf, m_serr;
    int         m_ch, m_len, m_beat;

    // Observed handshakes, recorded from the DUT for literal checks.
    int         log_ch[$];
    logic [7:0] log_d[$];
    bit         log_l[$];
    int         done_cnt = 0;
    bit         prev_stall [N_CH];
    logic [7:0] prev_dat   [N_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_done = 0; m_ovf = 0; m_serr = 0;
        m_ch = 0; m_len = 0; m_beat = 0;
    endtask

    function automatic bit model_last();
        if (m_len != 0) return (m_beat == m_len - 1);
        return (q.size() == 1);
    endfunction

    task automatic compare();
        logic [N_CH-1:0]        ev = '0;
        logic [N_CH-1:0]        el = '0;
        logic [N_CH*DATA_W-1:0] ed = '0;
        if (m_busy && q.size() > 0) begin
            ev[m_ch]          = 1'b1;
            el[m_ch]          = model_last();
            ed[m_ch*8 +: 8]   = q[0];
        end
        chk("tvalid", tvalid, ev);
        chk("tlast", tlast, el);
        chk("tdata", tdata, ed);
        chk("count", buff_count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("busy", busy, m_busy);
        chk("pkt_done", pkt_done, m_done);
        chk("overflow", overflow, m_ovf);
        chk("sel_err", sel_err, m_serr);
        if (pkt_done) done_cnt++;
        for (int c = 0; c < N_CH; c++) begin
            if (rst && prev_stall[c]) begin
                chk("stall_valid", tvalid[c], 1'b1);
                chk("stall_data", tdata[c*8 +: 8], prev_dat[c]);
            end
            if (tvalid[c] && tready[c]) begin
                log_ch.push_back(c);
                log_d.push_back(tdata[c*8 +: 8]);
                log_l.push_back(tlast[c]);
            end
            prev_stall[c] = rst && tvalid[c] && !tready[c];
            prev_dat[c]   = tdata[c*8 +: 8];
        end
    endtask

    task automatic model_update();
        int sz  = q.size();
        bit hs  = m_busy && sz > 0 && tready[m_ch];
        bit lst = hs && model_last();
        bit acc = push && (sz < DEPTH || hs);
        bit bad_start = !m_busy && op_en && sz > 0 && int'(sel) >= N_CH;
        m_ovf  = (push && !acc) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
        m_serr = bad_start ? 1'b1 : (clr_err ? 1'b0 : m_serr);
        m_done = lst;
        if (hs) void'(q.pop_front());
        if (acc) q.push_back(din);
        if (m_busy) begin
            if (hs) begin
                m_beat++;
                if (lst) m_busy = 0;
            end
        end else if (op_en && sz > 0 && int'(sel) < N_CH) begin
            m_busy = 1; m_ch = int'(sel); m_len = int'(pkt_len); m_beat = 0;
        end
    endtask

    // One clock: settle, check, advance the model on the edge, return at negedge.
    task automatic cycle();
        #1;
        if (!rst) model_reset();
        compare();
        @(posedge clk);
        if (rst) model_update();
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_ch.delete(); log_d.delete(); log_l.delete();
    endtask

    initial begin
        logic [7:0] t2 [4];
        t2 = '{8'd11, 8'd22, 8'd33, 8'd44};
        model_reset();
        for (int c = 0; c < N_CH; c++) begin prev_stall[c] = 0; prev_dat[c] = '0; end
        @(negedge clk);

        // Reset held with push active.
        rst = 0; push = 1; din = 8'hEE;
        repeat (3) begin
            cycle();
            chk("rst_count", buff_count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_tvalid", tvalid, 0);
        end
        push = 0; rst = 1;
        cycle();

        // Framing on channel 0.
        clear_log(); done_cnt = 0;
        for (int i = 0; i < 4; i++) begin push = 1; din = t2[i]; cycle(); end
        push = 0; pkt_len = 4; sel = 0; op_en = 1; tready = '1;
        repeat (12) cycle();
        op_en = 0;
        chk("t2_n", log_d.size(), 4);
        for (int i = 0; i < 4 && i < log_d.size(); i++) begin
            chk("t2_data", log_d[i], t2[i]);
            chk("t2_ch", log_ch[i], 0);
            chk("t2_last", log_l[i], i == 3);
        end
        chk("t2_done", done_cnt, 1);

        // Per-packet routing with sel changing mid-packet.
        clear_log();
        for (int i = 0; i < 8; i++) begin push = 1; din = 8'(i + 1); cycle(); end
        push = 0; pkt_len = 2; op_en = 1; tready = '1;
        for (int n = 0; n < 40 && log_d.size() < 8; n++) begin
            sel = (log_d.size() >= 1) ? 3'd3 : 3'd1;
            cycle();
        end
        op_en = 0;
        chk("t3_n", log_d.size(), 8);
        for (int i = 0; i < 8 && i < log_d.size(); i++) begin
            chk("t3_data", log_d[i], i + 1);
            chk("t3_ch", log_ch[i], (i < 2) ? 1 : 3);
            chk("t3_last", log_l[i], (i % 2) == 1);
        end

        // Flush mode under random backpressure.
        clear_log();
        for (int i = 0; i < 3; i++) begin push = 1; din = 8'hA1 + 8'(i); cycle(); end
        push = 0; pkt_len = 0; sel = 2; op_en = 1;
        for (int n = 0; n < 60; n++) begin
            tready = ($urandom % 2) ? 5'b00100 : 5'b00000;
            cycle();
        end
        op_en = 0; tready = '0;
        chk("t4_n", log_d.size(), 3);
        for (int i = 0; i < 3 && i < log_d.size(); i++) begin
            chk("t4_data", log_d[i], 8'hA1 + 8'(i));
            chk("t4_ch", log_ch[i], 2);
            chk("t4_last", log_l[i], i == 2);
        end

        // Fill to overflow, then push with a simultaneous pop at full.
        clear_log();
        for (int i = 0; i < 17; i++) begin push = 1; din = 8'(100 + i); cycle(); end
        push = 0;
        chk("t5_count", buff_count, 16);
        chk("t5_full", full, 1);
        chk("t5_ovf", overflow, 1);
        clr_err = 1; cycle(); clr_err = 0;
        op_en = 1; sel = 0; pkt_len = 0; cycle();
        op_en = 0; tready = 5'b00001; push = 1; din = 8'd99; cycle();
        push = 0;
        chk("t5_count_pp", buff_count, 16);
        chk("t5_ovf_pp", overflow, 0);
        repeat (30) cycle();
        chk("t5_n", log_d.size(), 17);
        for (int i = 0; i < 17 && i < log_d.size(); i++) begin
            chk("t5_data", log_d[i], (i < 16) ? 100 + i : 99);
            chk("t5_last", log_l[i], i == 16);
        end

        // Bad select, then reset in the middle of a packet.
        tready = '1; push = 1; din = 8'h55; cycle(); push = 0;
        op_en = 1; sel = 7; cycle();
        op_en = 0; cycle();
        chk("t6_selerr", sel_err, 1);
        chk("t6_tvalid", tvalid, 0);
        chk("t6_busy", busy, 0);
        clr_err = 1; cycle(); clr_err = 0;
        tready = '0; sel = 1; pkt_len = 3; op_en = 1;
        push = 1; din = 8'h66; cycle(); push = 0;
        cycle();
        chk("t6_busy_pre", busy, 1);
        rst = 0; op_en = 0;
        #1;
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_tdata", tdata, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", buff_count, 0);
        cycle(); cycle();
        rst = 1; cycle();

        // Randomised traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            push    = ($urandom % 2) == 1;
            din     = 8'($urandom);
            op_en   = ($urandom % 10) < 7;
            sel     = (($urandom % 8) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            pkt_len = 8'($urandom_range(0, 6));
            clr_err = ($urandom % 20) == 0;
            tready  = 5'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
